// File: rtl/pkt_pkg.sv
// Shared types and defaults for the packet transfer path.
// Used by pkt_xfer and the packet control FSM.
package pkt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        DISCARD,
        RD_ACK,
        HOLD,
        SEND,
        WR_ACK
    } xfer_state_t;

    localparam int PKT_DATA_W = 32;
    localparam int PKT_DEPTH  = 256;

endpackage

// File: rtl/pkt_buf.sv
// Packet storage: one synchronous write port, one asynchronous read port.
// The array is deliberately not reset.
module pkt_buf #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_xfer.sv
// Packet transfer engine: captures one packet on rd_ctrl, replays it on wr_ctrl.
// Define PKT_XFER_OVF_CNT_EN to add the saturating ovf_cnt output.
module pkt_xfer
    import pkt_pkg::*;
#(
    parameter int DATA_W = PKT_DATA_W,
    parameter int DEPTH  = PKT_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_ctrl,
    input  logic              wr_ctrl,
    output logic              rd_ctrl_rdy,
    output logic              wr_ctrl_rdy,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  pkt_len,
`ifdef PKT_XFER_OVF_CNT_EN
    output logic              truncated,
    output logic [15:0]       ovf_cnt
`else
    output logic              truncated
`endif
);

    localparam int AW = $clog2(DEPTH);

    xfer_state_t       state;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [DATA_W-1:0] rdata;
    logic              wr_en;
    logic              at_last;
    logic              enter_discard;

    assign wr_en   = (state == CAPTURE) && in_valid;
    assign at_last = CNT_W'(rptr) == (pkt_len - CNT_W'(1));

    // The DEPTH-th word arrived and the packet keeps going.
    assign enter_discard = wr_en && !in_last
                        && (pkt_len == CNT_W'(DEPTH - 1));

    assign out_last = out_valid && at_last;
    assign out_data = out_valid ? rdata : '0;

    pkt_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buf (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr),
        .wdata (in_data),
        .raddr (rptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            pkt_len     <= '0;
            truncated   <= 1'b0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            rd_ctrl_rdy <= 1'b0;
            wr_ctrl_rdy <= 1'b0;
        end else begin
            rd_ctrl_rdy <= 1'b0;
            wr_ctrl_rdy <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_ctrl) begin
                        state     <= CAPTURE;
                        wptr      <= '0;
                        pkt_len   <= '0;
                        truncated <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (in_valid) begin
                        wptr    <= wptr + 1'b1;
                        pkt_len <= pkt_len + 1'b1;
                        if (in_last) begin
                            state       <= RD_ACK;
                            in_ready    <= 1'b0;
                            rd_ctrl_rdy <= 1'b1;
                        end else if (enter_discard) begin
                            state     <= DISCARD;
                            truncated <= 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (in_valid && in_last) begin
                        state       <= RD_ACK;
                        in_ready    <= 1'b0;
                        rd_ctrl_rdy <= 1'b1;
                    end
                end
                RD_ACK: begin
                    state <= HOLD;
                end
                HOLD: begin
                    if (wr_ctrl) begin
                        state     <= SEND;
                        rptr      <= '0;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (at_last) begin
                            state       <= WR_ACK;
                            out_valid   <= 1'b0;
                            wr_ctrl_rdy <= 1'b1;
                        end else begin
                            rptr <= rptr + 1'b1;
                        end
                    end
                end
                WR_ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef PKT_XFER_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_cnt <= '0;
        end else if (enter_discard && ovf_cnt != 16'hFFFF) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`endif

endmodule
